rvfi_trace_tx: RTL

//  Retirement-trace transmitter: the producer-side counterpart of the RVFI checker path.
//  - Captures core0 RVFI retirement records and stamps each with a 64-bit order number.
//  - Buffers records in a FIFO and serialises each one as 32-bit words on a valid/ready

---
 rtl/rvfi_trace_tx.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rvfi_trace_tx.sv
// rvfi_trace_tx: retirement-trace transmitter.
// Captures RVFI retirement records, stamps each one with a 64-bit order number,
// buffers them in a FIFO and serialises each record as 32-bit words on a
// valid/ready stream. tx_last marks the final word of a record.
// Optional feature macro RVFI_TRACE_MEM_EN adds the memory-access ports and
// extends every record from 6 to 8 words.
module rvfi_trace_tx #(
   parameter int DEPTH  = 16,
   parameter int DROP_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     rvfi_valid,
   input  logic [31:0]              rvfi_insn,
   input  logic [31:0]              rvfi_pc_rdata,
   input  logic [4:0]               rvfi_rd_addr,
   input  logic [31:0]              rvfi_rd_wdata,
   input  logic [1:0]               rvfi_mode,
   input  logic                     rvfi_intr,
`ifdef RVFI_TRACE_MEM_EN
   input  logic [31:0]              rvfi_mem_addr,
   input  logic [31:0]              rvfi_mem_rdata,
   input  logic [31:0]              rvfi_mem_wdata,
   input  logic [3:0]               rvfi_mem_rmask,
   input  logic [3:0]               rvfi_mem_wmask,
`endif
   output logic [31:0]              tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic                     tx_last,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [DROP_W-1:0]        drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
`ifdef RVFI_TRACE_MEM_EN
   localparam int NWORDS = 8;
`else
   localparam int NWORDS = 6;
`endif
   localparam logic [2:0]        LAST_IDX = 3'(NWORDS - 1);
   localparam logic [LW-1:0]     FULL_LVL = LW'(DEPTH);
   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   typedef struct packed {
      logic [63:0] order;
      logic [31:0] pc;
      logic [31:0] insn;
      logic [31:0] rd_wdata;
      logic [4:0]  rd;
      logic [1:0]  mode;
      logic        intr;
      logic [7:0]  drops;
`ifdef RVFI_TRACE_MEM_EN
      logic [31:0] mem_addr;
      logic [31:0] mem_data;   // already selected: write data for stores, read data otherwise
      logic [3:0]  rmask;
      logic [3:0]  wmask;
`endif
   } rec_t;

   typedef enum logic {IDLE, SEND} state_t;

   state_t            state_q, state_d;
   logic [2:0]        idx_q, idx_d;
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]     count_q, count_d;
   logic [63:0]       order_q;
   logic [DROP_W-1:0] drop_q, drop_d;
   rec_t              mem_q [DEPTH];
   rec_t              wr_rec;
   rec_t              head;
   logic              capture, full, push, drop, pop;
   logic [31:0]       word;
   logic [7:0]        low_byte;

   // Full is judged on the registered level, so a same-cycle pop never rescues a push.
   assign capture    = rvfi_valid & enable;
   assign full       = (count_q == FULL_LVL);
   assign push       = capture & ~full;
   assign drop       = capture & full;
   assign pop        = (state_q == SEND) & tx_ready & (idx_q == LAST_IDX);
   assign count_d    = count_q + LW'(push) - LW'(pop);
   assign head       = mem_q[rd_ptr_q];
   assign fifo_level = count_q;
   assign drop_count = drop_q;

   // Assemble the record written on a push; the pending drop count rides in its header.
   always_comb begin
      wr_rec          = '0;
      wr_rec.order    = order_q;
      wr_rec.pc       = rvfi_pc_rdata;
      wr_rec.insn     = rvfi_insn;
      wr_rec.rd_wdata = rvfi_rd_wdata;
      wr_rec.rd       = rvfi_rd_addr;
      wr_rec.mode     = rvfi_mode;
      wr_rec.intr     = rvfi_intr;
      wr_rec.drops    = 8'(drop_q);
`ifdef RVFI_TRACE_MEM_EN
      wr_rec.mem_addr = rvfi_mem_addr;
      wr_rec.mem_data = (rvfi_mem_wmask != 4'h0) ? rvfi_mem_wdata : rvfi_mem_rdata;
      wr_rec.rmask    = rvfi_mem_rmask;
      wr_rec.wmask    = rvfi_mem_wmask;
`endif
   end

   // Saturating drop counter, cleared once its value has been handed to a stored record.
   always_comb begin
      drop_d = drop_q;
      if (push) begin
         drop_d = '0;
      end else if (drop && (drop_q != DROP_MAX)) begin
         drop_d = drop_q + DROP_W'(1);
      end
   end

   // Record storage; payload carries no reset, validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_rec;
      end
   end

   // Control registers: FSM, word index, FIFO pointers/level, order and drop counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         order_q  <= '0;
         drop_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         drop_q  <= drop_d;
         if (capture) order_q  <= order_q + 64'd1;
         if (push)    wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   // Word select for the head record; words come straight from storage, so they stay stable.
   always_comb begin
`ifdef RVFI_TRACE_MEM_EN
      low_byte = {head.rmask, head.wmask};
`else
      low_byte = 8'h00;
`endif
      word = '0;
      case (idx_q)
         3'd0: word = {8'hA5, head.mode, head.intr, head.rd, head.drops, low_byte};
         3'd1: word = head.order[31:0];
         3'd2: word = head.order[63:32];
         3'd3: word = head.pc;
         3'd4: word = head.insn;
         3'd5: word = head.rd_wdata;
`ifdef RVFI_TRACE_MEM_EN
         3'd6: word = head.mem_addr;
         3'd7: word = head.mem_data;
`endif
         default: word = '0;
      endcase
   end

   // Serialiser FSM: IDLE waits for a record, SEND walks its words and chains records without a bubble.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      tx_data  = '0;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               state_d = SEND;
               idx_d   = '0;
            end
         end
         SEND: begin
            tx_valid = 1'b1;
            tx_data  = word;
            tx_last  = (idx_q == LAST_IDX);
            if (tx_ready) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = (count_d != '0) ? SEND : IDLE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

endmodule
